// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;
  localparam int unsigned REG_ZERO_ADDR = 0;

  // A single-entry file would need a zero-width address, so clamp to 1 bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word: enable-gated register with synchronous active-high clear.
module regfile_word #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired-zero entry 0 and optional write-to-read bypass.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = REGFILE_WIDTH,
  parameter int unsigned DEPTH     = REGFILE_DEPTH,
  parameter bit          ZERO_REG0 = 1'b1,
  parameter bit          BYPASS    = 1'b0,
  localparam int unsigned ADDR_W   = addr_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  output logic [WIDTH-1:0]  rd_data1_o,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [WIDTH-1:0]  rd_data2_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO_ADDR);

  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] entries [DEPTH];
  logic             byp_ok;

  always_comb begin
    wr_sel = '0;
    if (wr_en_i) begin
      wr_sel[wr_addr_i] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG0 && (i == REG_ZERO_ADDR)) begin : g_zero
      // Constant entry: no storage, its write enable is deliberately dropped.
      logic unused_sel;
      assign unused_sel = wr_sel[i];
      assign entries[i] = '0;
    end else begin : g_store
      regfile_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (wr_sel[i]),
        .d_i     (wr_data_i),
        .q_o     (entries[i])
      );
    end
  end

  // Forwarding never targets the zero entry and is masked while clearing.
  assign byp_ok = BYPASS && wr_en_i && !reset_i &&
                  !(ZERO_REG0 && (wr_addr_i == ZeroAddr));

  always_comb begin
    rd_data1_o = entries[rd_addr1_i];
    if (byp_ok && (rd_addr1_i == wr_addr_i)) begin
      rd_data1_o = wr_data_i;
    end
  end

  always_comb begin
    rd_data2_o = entries[rd_addr2_i];
    if (byp_ok && (rd_addr2_i == wr_addr_i)) begin
      rd_data2_o = wr_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param across three configurations.
module tb_regfile_param;

  logic        clk;
  logic        reset, wr_en;
  logic [4:0]  wr_addr, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] a1, a2, b1, b2;

  logic        c_reset, c_wr_en;
  logic [1:0]  c_wa, c_ra1, c_ra2;
  logic [7:0]  c_wd;
  logic [7:0]  c1, c2;

  int total = 0;
  int bad   = 0;

  // Reference contents: a = zero-reg, no bypass; b = no zero-reg, bypass; c = 8x4.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [7:0]  mc [4];

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG0(1'b1), .BYPASS(1'b0)) u_a (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wd),
    .rd_addr1_i(ra1), .rd_data1_o(a1), .rd_addr2_i(ra2), .rd_data2_o(a2)
  );

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG0(1'b0), .BYPASS(1'b1)) u_b (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wd),
    .rd_addr1_i(ra1), .rd_data1_o(b1), .rd_addr2_i(ra2), .rd_data2_o(b2)
  );

  regfile_param #(.WIDTH(8), .DEPTH(4), .ZERO_REG0(1'b1), .BYPASS(1'b0)) u_c (
    .clk_i(clk), .reset_i(c_reset), .wr_en_i(c_wr_en), .wr_addr_i(c_wa), .wr_data_i(c_wd),
    .rd_addr1_i(c_ra1), .rd_data1_o(c1), .rd_addr2_i(c_ra2), .rd_data2_o(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] <= '0;
        mb[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_addr != 5'd0) ma[wr_addr] <= wd;
      mb[wr_addr] <= wd;
    end
    if (c_reset) begin
      for (int i = 0; i < 4; i++) mc[i] <= '0;
    end else if (c_wr_en && c_wa != 2'd0) begin
      mc[c_wa] <= c_wd;
    end
  end

  function automatic logic [31:0] exp_a(input logic [4:0] ad);
    return (ad == 5'd0) ? 32'h0 : ma[ad];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] ad);
    if (!reset && wr_en && ad == wr_addr) return wd;
    return mb[ad];
  endfunction

  function automatic logic [7:0] exp_c(input logic [1:0] ad);
    return (ad == 2'd0) ? 8'h0 : mc[ad];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; wr_en = 0; c_reset = 0; c_wr_en = 0;
  endtask

  task automatic test_reset();
    reset = 1; c_reset = 1;
    tick();
    idle();
    wr_en = 1; wr_addr = 5; wd = 32'hDEADBEEF;
    c_wr_en = 1; c_wa = 2; c_wd = 8'h5A;
    tick();
    idle();
    reset = 1; c_reset = 1;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      total += 4;
      if (a1 !== 32'h0) begin bad++; $display("FAIL reset_a1 addr=%0d got=%h exp=0", i, a1); end
      if (a2 !== 32'h0) begin bad++; $display("FAIL reset_a2 addr=%0d got=%h exp=0", 31 - i, a2); end
      if (b1 !== 32'h0) begin bad++; $display("FAIL reset_b1 addr=%0d got=%h exp=0", i, b1); end
      if (b2 !== 32'h0) begin bad++; $display("FAIL reset_b2 addr=%0d got=%h exp=0", 31 - i, b2); end
    end
    for (int i = 0; i < 4; i++) begin
      c_ra1 = 2'(i); c_ra2 = 2'(i);
      #1;
      total += 2;
      if (c1 !== 8'h0) begin bad++; $display("FAIL reset_c1 addr=%0d got=%h exp=0", i, c1); end
      if (c2 !== 8'h0) begin bad++; $display("FAIL reset_c2 addr=%0d got=%h exp=0", i, c2); end
    end
  endtask

  task automatic test_basic();
    wr_en = 1; wr_addr = 7; wd = 32'h12345678;
    tick();
    wr_addr = 31; wd = 32'hCAFEF00D;
    tick();
    idle();
    ra1 = 7; ra2 = 31;
    #1;
    total += 4;
    if (a1 !== 32'h12345678) begin bad++; $display("FAIL basic_a1 got=%h exp=12345678", a1); end
    if (a2 !== 32'hCAFEF00D) begin bad++; $display("FAIL basic_a2 got=%h exp=cafef00d", a2); end
    if (b1 !== 32'h12345678) begin bad++; $display("FAIL basic_b1 got=%h exp=12345678", b1); end
    if (b2 !== 32'hCAFEF00D) begin bad++; $display("FAIL basic_b2 got=%h exp=cafef00d", b2); end
  endtask

  task automatic test_zero();
    wr_en = 1; wr_addr = 0; wd = 32'hFFFFFFFF;
    ra1 = 0; ra2 = 0;
    #1;
    total += 2;
    if (a1 !== 32'h0) begin bad++; $display("FAIL zero_during_a1 got=%h exp=0", a1); end
    if (b1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_byp_b1 got=%h exp=ffffffff", b1); end
    tick();
    idle();
    #1;
    total += 4;
    if (a1 !== 32'h0) begin bad++; $display("FAIL zero_a1 got=%h exp=0", a1); end
    if (a2 !== 32'h0) begin bad++; $display("FAIL zero_a2 got=%h exp=0", a2); end
    if (b1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_b1 got=%h exp=ffffffff", b1); end
    if (b2 !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_b2 got=%h exp=ffffffff", b2); end
  endtask

  task automatic test_same_cycle();
    wr_en = 1; wr_addr = 3; wd = 32'h11111111;
    tick();
    wd = 32'h22222222; ra1 = 3; ra2 = 3;
    #1;
    total += 2;
    if (a1 !== 32'h11111111) begin bad++; $display("FAIL same_old_a1 got=%h exp=11111111", a1); end
    if (b1 !== 32'h22222222) begin bad++; $display("FAIL same_byp_b1 got=%h exp=22222222", b1); end
    tick();
    idle();
    #1;
    total += 2;
    if (a1 !== 32'h22222222) begin bad++; $display("FAIL same_new_a1 got=%h exp=22222222", a1); end
    if (b2 !== 32'h22222222) begin bad++; $display("FAIL same_new_b2 got=%h exp=22222222", b2); end
  endtask

  task automatic test_collision();
    wr_en = 1; wr_addr = 9; wd = 32'h0BADF00D;
    tick();
    reset = 1; wd = 32'hABCDABCD; ra1 = 9; ra2 = 9;
    #1;
    total += 1;
    if (b1 !== 32'h0BADF00D) begin bad++; $display("FAIL coll_nobyp_b1 got=%h exp=0badf00d", b1); end
    tick();
    reset = 0;
    // Reset held a second cycle with the write still requested.
    reset = 1;
    tick();
    idle();
    #1;
    total += 3;
    if (a1 !== 32'h0) begin bad++; $display("FAIL coll_a1 got=%h exp=0", a1); end
    if (b1 !== 32'h0) begin bad++; $display("FAIL coll_b1 got=%h exp=0", b1); end
    if (b2 !== 32'h0) begin bad++; $display("FAIL coll_b2 got=%h exp=0", b2); end
    wr_en = 1; wd = 32'h13579BDF;
    tick();
    idle();
    #1;
    total += 1;
    if (a1 !== 32'h13579BDF) begin bad++; $display("FAIL coll_after_a1 got=%h exp=13579bdf", a1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr_en = 1; wr_addr = 12; ra1 = 12;
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      wd = v;
      tick();
      total += 1;
      if (a1 !== v) begin bad++; $display("FAIL b2b_a1 k=%0d got=%h exp=%h", k, a1, v); end
    end
    idle();
  endtask

  task automatic test_sweep();
    c_wr_en = 1; c_wa = 1; c_wd = 8'h3C;
    tick();
    c_wa = 2; c_wd = 8'hC3;
    tick();
    c_wa = 3; c_wd = 8'hA5;
    tick();
    c_wa = 0; c_wd = 8'hFF;
    tick();
    idle();
    c_ra1 = 3; c_ra2 = 1;
    #1;
    total += 2;
    if (c1 !== 8'hA5) begin bad++; $display("FAIL sweep_c3 got=%h exp=a5", c1); end
    if (c2 !== 8'h3C) begin bad++; $display("FAIL sweep_c1 got=%h exp=3c", c2); end
    c_ra1 = 2; c_ra2 = 0;
    #1;
    total += 2;
    if (c1 !== 8'hC3) begin bad++; $display("FAIL sweep_c2 got=%h exp=c3", c1); end
    if (c2 !== 8'h00) begin bad++; $display("FAIL sweep_c0 got=%h exp=0", c2); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [7:0]  ec;
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 31) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 5'($urandom_range(0, 31));
      wd      = $urandom;
      ra1     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      ra2     = 5'($urandom_range(0, 31));
      c_reset = ($urandom_range(0, 31) == 0);
      c_wr_en = $urandom_range(0, 1);
      c_wa    = 2'($urandom_range(0, 3));
      c_wd    = 8'($urandom);
      c_ra1   = 2'($urandom_range(0, 3));
      c_ra2   = 2'($urandom_range(0, 3));
      #1;
      total += 6;
      e = exp_a(ra1);
      if (a1 !== e) begin bad++; $display("FAIL rnd_a1 n=%0d addr=%0d got=%h exp=%h", n, ra1, a1, e); end
      e = exp_a(ra2);
      if (a2 !== e) begin bad++; $display("FAIL rnd_a2 n=%0d addr=%0d got=%h exp=%h", n, ra2, a2, e); end
      e = exp_b(ra1);
      if (b1 !== e) begin bad++; $display("FAIL rnd_b1 n=%0d addr=%0d got=%h exp=%h", n, ra1, b1, e); end
      e = exp_b(ra2);
      if (b2 !== e) begin bad++; $display("FAIL rnd_b2 n=%0d addr=%0d got=%h exp=%h", n, ra2, b2, e); end
      ec = exp_c(c_ra1);
      if (c1 !== ec) begin bad++; $display("FAIL rnd_c1 n=%0d addr=%0d got=%h exp=%h", n, c_ra1, c1, ec); end
      ec = exp_c(c_ra2);
      if (c2 !== ec) begin bad++; $display("FAIL rnd_c2 n=%0d addr=%0d got=%h exp=%h", n, c_ra2, c2, ec); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    wr_addr = 0; wd = 0; ra1 = 0; ra2 = 0;
    c_wa = 0; c_wd = 0; c_ra1 = 0; c_ra2 = 0;
    #2;
    test_reset();
    test_basic();
    test_zero();
    test_same_cycle();
    test_collision();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
